// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master to one-slave memory bus arbiter with a waitrequest watchdog.
//   Master 0 is the instruction fetch port and master 1 is the data port.
//   The owner's request is passed through to the slave combinationally.
//   A transfer that stalls on slave waitrequest for WAIT_LIMIT cycles is
//   aborted. The abort lasts one cycle and pulses bus_error.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : round-robin arbitration when both masters request
//                 (the master that did not own the last transfer wins)
//     undefined : fixed priority, master 1 wins when both request
//
//   Ports
//     clk, reset                  clock, asynchronous active-low reset
//     m0_* / m1_*                 master request inputs and waitrequest outputs
//     m_readdata                  read data returned to both masters
//     address, writedata, read,
//     write, byteenable           slave-side request
//     readdata, waitrequest       slave response
//     grant                       one-hot owner (bit0 = m0, bit1 = m1)
//     bus_error                   one-cycle pulse when the watchdog aborts
//
//   state | meaning
//   IDLE  | no owner, arbitrating pending requests
//   OWN0  | master 0 owns the slave
//   OWN1  | master 1 owns the slave
//   ABORT | watchdog abort, owner released with zero read data
module mem_bus_arbiter #(
    parameter int unsigned WAIT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m_readdata,
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic [1:0]  grant,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    localparam logic [15:0] CNT_LAST = 16'(WAIT_LIMIT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        req0;
    logic        req1;
    logic        own_req;
    logic        pick_m1;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign own_req = (state == OWN1) ? req1 : req0;

`ifdef ARB_ROUND_ROBIN_EN
    // last_owner: 1 = master 1 owned the most recent transfer
    logic last_owner;
    assign pick_m1 = req1 && (!req0 || !last_owner);
`else
    assign pick_m1 = req1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            bus_error  <= 1'b0;
            wait_cnt   <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 16'd0;
                    if (req0 || req1) begin
                        if (pick_m1) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end
                    end
                end
                OWN0, OWN1: begin
                    // Completion and a dropped request both just release the bus.
                    if (!own_req || !waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= (state == OWN1);
`endif
                    end else if (wait_cnt >= CNT_LAST) begin
                        state     <= ABORT;
                        bus_error <= 1'b1;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                    grant <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner <= grant[1];
`endif
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        address        = 32'h0;
        writedata      = 32'h0;
        byteenable     = 4'h0;
        read           = 1'b0;
        write          = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m_readdata     = readdata;
        case (state)
            OWN0: begin
                address        = m0_address;
                writedata      = m0_writedata;
                byteenable     = m0_byteenable;
                read           = m0_read;
                write          = m0_write;
                m0_waitrequest = waitrequest;
            end
            OWN1: begin
                address        = m1_address;
                writedata      = m1_writedata;
                byteenable     = m1_byteenable;
                read           = m1_read;
                write          = m1_write;
                m1_waitrequest = waitrequest;
            end
            ABORT: begin
                m_readdata = 32'h0;
                if (grant[0]) m0_waitrequest = 1'b0;
                else          m1_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m0_address = '0, m0_writedata = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic [3:0]  m0_byteenable = '0;
    logic        m0_waitrequest;
    logic [31:0] m1_address = '0, m1_writedata = '0;
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [3:0]  m1_byteenable = '0;
    logic        m1_waitrequest;
    logic [31:0] m_readdata;
    logic [31:0] address, writedata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b1;
    logic [1:0]  grant;
    logic        bus_error;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_seen = 0;
    int err_seen = 0;

    mem_bus_arbiter #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
        .m_readdata(m_readdata),
        .address(address), .writedata(writedata),
        .read(read), .write(write), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest),
        .grant(grant), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write && !waitrequest && writedata == 32'hCAFEF00D) wr_seen++;
        if (bus_error) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_read", 32'(read), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        check("rst_address", address, 32'h0);
        step();
        reset = 1'b1;

        // single m0 read, slave stalls two cycles
        m0_address = 32'hBFC00000;
        m0_read    = 1'b1;
        #1;
        check("t1_idle_grant", 32'(grant), 32'h0);
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_address", address, 32'hBFC00000);
        check("t1_read", 32'(read), 32'h1);
        check("t1_m0_wait_stall", 32'(m0_waitrequest), 32'h1);
        step();
        waitrequest = 1'b0;
        readdata    = 32'h24020005;
        #1;
        check("t1_m0_wait_done", 32'(m0_waitrequest), 32'h0);
        check("t1_readdata", m_readdata, 32'h24020005);
        check("t1_m1_wait", 32'(m1_waitrequest), 32'h1);
        step();
        m0_read = 1'b0;
        #1;
        check("t1_back_idle", 32'(grant), 32'h0);
        check("t1_idle_address", address, 32'h0);

        // contention right after reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        m0_address    = 32'h2000;
        m0_read       = 1'b1;
        m1_address    = 32'h1000;
        m1_writedata  = 32'hCAFEF00D;
        m1_byteenable = 4'hF;
        m1_write      = 1'b1;
        step();
        check("t2_first_grant", 32'(grant), RR ? 32'h1 : 32'h2);
        if (!RR) begin
            check("t2_wdata", writedata, 32'hCAFEF00D);
            check("t2_be", 32'(byteenable), 32'hF);
            check("t2_addr", address, 32'h1000);
        end
        step();
        if (RR) m0_read = 1'b0; else m1_write = 1'b0;
        #1;
        check("t2_gap", 32'(grant), 32'h0);
        step();
        check("t2_second_grant", 32'(grant), RR ? 32'h2 : 32'h1);
        step();
        if (RR) m1_write = 1'b0; else m0_read = 1'b0;
        #1;
        check("t2_write_once", 32'(wr_seen), 32'h1);

        // continuous requests from both masters
        m0_read = 1'b1;
        m1_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t3_grant%0d", i), 32'(grant),
                  (RR && (i % 2 == 0)) ? 32'h1 : 32'h2);
            step();
            check($sformatf("t3_gap%0d", i), 32'(grant), 32'h0);
        end
        m0_read = 1'b0;
        m1_read = 1'b0;

        // watchdog abort on a stuck m1 read
        waitrequest = 1'b1;
        readdata    = 32'hDEADBEEF;
        m1_address  = 32'h3000;
        m1_read     = 1'b1;
        step();
        check("t4_grant", 32'(grant), 32'h2);
        step();
        step();
        step();
        check("t4_cycle4_grant", 32'(grant), 32'h2);
        check("t4_cycle4_err", 32'(bus_error), 32'h0);
        step();
        check("t4_abort_err", 32'(bus_error), 32'h1);
        check("t4_abort_read", 32'(read), 32'h0);
        check("t4_abort_m1_wait", 32'(m1_waitrequest), 32'h0);
        check("t4_abort_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("t4_abort_rdata", m_readdata, 32'h0);
        check("t4_abort_grant", 32'(grant), 32'h2);
        m1_read     = 1'b0;
        m0_address  = 32'h4000;
        m0_read     = 1'b1;
        waitrequest = 1'b0;
        step();
        check("t4_idle_err", 32'(bus_error), 32'h0);
        check("t4_idle_grant", 32'(grant), 32'h0);
        step();
        check("t4_m0_grant", 32'(grant), 32'h1);
        check("t4_m0_wait", 32'(m0_waitrequest), 32'h0);
        check("t4_m0_rdata", m_readdata, 32'hDEADBEEF);
        check("t4_m0_addr", address, 32'h4000);
        step();
        m0_read = 1'b0;
        #1;
        check("t4_err_count", 32'(err_seen), 32'h1);

        // owner drops its strobe while stalled
        waitrequest = 1'b1;
        m1_read     = 1'b1;
        step();
        check("t5_grant", 32'(grant), 32'h2);
        m1_read = 1'b0;
        #1;
        check("t5_read_drop", 32'(read), 32'h0);
        step();
        check("t5_idle_grant", 32'(grant), 32'h0);
        check("t5_no_err", 32'(bus_error), 32'h0);

        // reset in the middle of a stalled m0 transfer
        m0_read = 1'b1;
        step();
        check("t6_read", 32'(read), 32'h1);
        check("t6_grant", 32'(grant), 32'h1);
        reset = 1'b0;
        #1;
        check("t6_rst_read", 32'(read), 32'h0);
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_err", 32'(bus_error), 32'h0);
        check("t6_rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("t6_rst_addr", address, 32'h0);
        step();
        step();
        reset       = 1'b1;
        waitrequest = 1'b0;
        #1;
        check("t6_release_grant", 32'(grant), 32'h0);
        step();
        check("t6_regrant", 32'(grant), 32'h1);
        step();
        m0_read = 1'b0;
        #1;
        check("t6_err_count", 32'(err_seen), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
